// File: rtl/icache_miss_handler_i_2_pkg.sv
// Shared constants and state encoding for the instruction-cache miss/fill engine.
// Holds the default address/data width, way and block-offset widths, the address
// field boundaries (byte, word offset, tag+index) and the FSM state type.
package icache_miss_handler_i_2_pkg;

   localparam int unsigned ADDRESSSIZE = 32;
   localparam int unsigned WAY_BITS    = 2;
   localparam int unsigned BLK_WORDS   = 4;
   localparam int unsigned OFF_BITS    = 2;

   // Byte-within-word bits of a 32-bit word address.
   localparam int unsigned BYTE_BITS   = 2;

   // Word offset inside the block.
   localparam int unsigned OFF_LSB     = BYTE_BITS;
   localparam int unsigned OFF_MSB     = OFF_LSB + OFF_BITS - 1;

   // Tag and index are carried together as the block address.
   localparam int unsigned BLK_LSB     = OFF_MSB + 1;
   localparam int unsigned BLK_MSB     = ADDRESSSIZE - 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUS_REQ = 2'd1,
      FETCH   = 2'd2,
      UPDATE  = 2'd3
   } state_t;

endpackage

// File: rtl/icache_fill_counter_i_2.sv
// Fill counter for the miss engine: a wrapping word-offset counter, a count of
// accepted words, and a combinational flag marking the last word of the block.
// Ports: clk, rst_n; load/start restart a fill at a given offset; inc accepts one
// word; offset is the current word offset; last_c is high when the accepted word
// completes the block.
module icache_fill_counter_i_2 #(
   parameter int unsigned BLK_WORDS = 4,
   parameter int unsigned OFF_BITS  = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic [OFF_BITS-1:0] start,
   input  logic                inc,
   output logic [OFF_BITS-1:0] offset,
   output logic                last_c
);

   logic [OFF_BITS-1:0] count;

   // Offset wraps naturally because BLK_WORDS is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         offset <= '0;
         count  <= '0;
      end else if (load) begin
         offset <= start;
         count  <= '0;
      end else if (inc) begin
         offset <= offset + OFF_BITS'(1);
         count  <= count + OFF_BITS'(1);
      end
   end

   assign last_c = inc && (count == OFF_BITS'(BLK_WORDS - 1));

endmodule

// File: rtl/icache_miss_handler_i_2.sv
// Instruction-cache miss/fill engine. Reports hits to the LRU controller, and on a
// miss requests the shared bus, fetches the whole block into the victim way,
// returns the requested word and reports the victim way as accessed.
// Ports: processor side (PrRd, Address, Hit, Hit_way, CPU_stall, Data_Bus[_valid]),
// LRU side (LRU_replacement_proc, Blk_accessed, Blk_access_valid), shared bus
// (Com_Bus_Req/Gnt, Address_Com, Data_Bus_Com, Mem_Rdy), array write port (Fill_*).
// Build option: ICACHE_CWF_EN selects critical-word-first fetch order.
module icache_miss_handler_i_2 #(
   parameter int unsigned ADDRESSSIZE = icache_miss_handler_i_2_pkg::ADDRESSSIZE,
   parameter int unsigned WAY_BITS    = icache_miss_handler_i_2_pkg::WAY_BITS,
   parameter int unsigned BLK_WORDS   = icache_miss_handler_i_2_pkg::BLK_WORDS,
   parameter int unsigned OFF_BITS    = icache_miss_handler_i_2_pkg::OFF_BITS
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   PrRd,
   input  logic [ADDRESSSIZE-1:0] Address,
   input  logic                   Hit,
   input  logic [WAY_BITS-1:0]    Hit_way,
   input  logic [WAY_BITS-1:0]    LRU_replacement_proc,
   output logic [WAY_BITS-1:0]    Blk_accessed,
   output logic                   Blk_access_valid,
   output logic                   CPU_stall,
   output logic [ADDRESSSIZE-1:0] Data_Bus,
   output logic                   Data_Bus_valid,
   output logic                   Com_Bus_Req,
   input  logic                   Com_Bus_Gnt,
   output logic [ADDRESSSIZE-1:0] Address_Com,
   input  logic [ADDRESSSIZE-1:0] Data_Bus_Com,
   input  logic                   Mem_Rdy,
   output logic                   Fill_we,
   output logic [WAY_BITS-1:0]    Fill_way,
   output logic [OFF_BITS-1:0]    Fill_offset,
   output logic [ADDRESSSIZE-1:0] Fill_data
);

   import icache_miss_handler_i_2_pkg::*;

   localparam int unsigned OFS_LO = BYTE_BITS;
   localparam int unsigned BLK_LO = BYTE_BITS + OFF_BITS;

   state_t                    state;
   logic [ADDRESSSIZE-1:BLK_LO] blk_addr_q;
   logic [OFF_BITS-1:0]       req_off_q;
   logic [WAY_BITS-1:0]       victim_q;
   logic [OFF_BITS-1:0]       ctr;
   logic [OFF_BITS-1:0]       start_off;
   logic                      load_c;
   logic                      accept_c;
   logic                      last_c;
   logic                      unused_byte_bits;

   assign unused_byte_bits = ^Address[OFS_LO-1:0];

`ifdef ICACHE_CWF_EN
   assign start_off = req_off_q;
`else
   assign start_off = '0;
`endif

   // A word is accepted only while the grant is held.
   assign load_c   = (state == BUS_REQ) && Com_Bus_Gnt;
   assign accept_c = (state == FETCH) && Com_Bus_Gnt && Mem_Rdy;

   icache_fill_counter_i_2 #(
      .BLK_WORDS (BLK_WORDS),
      .OFF_BITS  (OFF_BITS)
   ) u_fill_counter (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load_c),
      .start  (start_off),
      .inc    (accept_c),
      .offset (ctr),
      .last_c (last_c)
   );

   // Array write port and stall are combinational so the write and stall land in the same cycle.
   assign Fill_we     = accept_c;
   assign Fill_way    = accept_c ? victim_q : '0;
   assign Fill_offset = accept_c ? ctr : '0;
   assign Fill_data   = accept_c ? Data_Bus_Com : '0;
   assign CPU_stall   = (state != IDLE) || (PrRd && !Hit);

   // Shared address bus is only driven while this engine owns the bus.
   assign Address_Com = ((state == FETCH) && Com_Bus_Gnt)
                      ? {blk_addr_q, ctr, {OFS_LO{1'b0}}}
                      : {ADDRESSSIZE{1'bz}};

   // Miss FSM with registered strobes and bus request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         blk_addr_q       <= '0;
         req_off_q        <= '0;
         victim_q         <= '0;
         Blk_accessed     <= '0;
         Blk_access_valid <= 1'b0;
         Data_Bus         <= '0;
         Data_Bus_valid   <= 1'b0;
         Com_Bus_Req      <= 1'b0;
      end else begin
         Blk_access_valid <= 1'b0;
         Data_Bus_valid   <= 1'b0;
         case (state)
            IDLE: begin
               if (PrRd && Hit) begin
                  Blk_accessed     <= Hit_way;
                  Blk_access_valid <= 1'b1;
               end else if (PrRd) begin
                  blk_addr_q  <= Address[ADDRESSSIZE-1:BLK_LO];
                  req_off_q   <= Address[BLK_LO-1:OFS_LO];
                  victim_q    <= LRU_replacement_proc;
                  Com_Bus_Req <= 1'b1;
                  state       <= BUS_REQ;
               end
            end
            BUS_REQ: begin
               if (Com_Bus_Gnt) state <= FETCH;
            end
            FETCH: begin
               if (!Com_Bus_Gnt) begin
                  state <= BUS_REQ;
               end else if (Mem_Rdy) begin
                  if (ctr == req_off_q) begin
                     Data_Bus       <= Data_Bus_Com;
                     Data_Bus_valid <= 1'b1;
                  end
                  if (last_c) begin
                     Blk_accessed     <= victim_q;
                     Blk_access_valid <= 1'b1;
                     Com_Bus_Req      <= 1'b0;
                     state            <= UPDATE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_miss_handler_i_2.sv
// Scoreboard bench for the instruction-cache miss/fill engine: a driver applies
// random per-cycle stimulus and a reference model queues the expected outputs; an
// independent monitor pops and compares whenever the DUT strobes.
module tb_icache_miss_handler_i_2;

   localparam int unsigned AW = 32;
   localparam int unsigned WB = 2;
   localparam int unsigned BW = 4;
   localparam int unsigned OB = 2;

   localparam int M_IDLE  = 0;
   localparam int M_REQ   = 1;
   localparam int M_FETCH = 2;
   localparam int M_UPD   = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          PrRd = 1'b0;
   logic [AW-1:0] Address = '0;
   logic          Hit = 1'b0;
   logic [WB-1:0] Hit_way = '0;
   logic [WB-1:0] LRU_replacement_proc = '0;
   logic [WB-1:0] Blk_accessed;
   logic          Blk_access_valid;
   logic          CPU_stall;
   logic [AW-1:0] Data_Bus;
   logic          Data_Bus_valid;
   logic          Com_Bus_Req;
   logic          Com_Bus_Gnt = 1'b0;
   logic [AW-1:0] Address_Com;
   logic [AW-1:0] Data_Bus_Com = '0;
   logic          Mem_Rdy = 1'b0;
   logic          Fill_we;
   logic [WB-1:0] Fill_way;
   logic [OB-1:0] Fill_offset;
   logic [AW-1:0] Fill_data;

   icache_miss_handler_i_2 dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .PrRd                 (PrRd),
      .Address              (Address),
      .Hit                  (Hit),
      .Hit_way              (Hit_way),
      .LRU_replacement_proc (LRU_replacement_proc),
      .Blk_accessed         (Blk_accessed),
      .Blk_access_valid     (Blk_access_valid),
      .CPU_stall            (CPU_stall),
      .Data_Bus             (Data_Bus),
      .Data_Bus_valid       (Data_Bus_valid),
      .Com_Bus_Req          (Com_Bus_Req),
      .Com_Bus_Gnt          (Com_Bus_Gnt),
      .Address_Com          (Address_Com),
      .Data_Bus_Com         (Data_Bus_Com),
      .Mem_Rdy              (Mem_Rdy),
      .Fill_we              (Fill_we),
      .Fill_way             (Fill_way),
      .Fill_offset          (Fill_offset),
      .Fill_data            (Fill_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned   cyc;
      logic [AW-1:0] val;
   } ev_t;

   typedef struct {
      int unsigned   cyc;
      logic [WB-1:0] way;
      logic [OB-1:0] off;
      logic [AW-1:0] data;
      logic [AW-1:0] addr;
   } fill_t;

   typedef struct {
      int unsigned cyc;
      logic        stall;
      logic        req;
   } lvl_t;

   ev_t   blk_q[$];
   ev_t   db_q[$];
   fill_t fill_q[$];
   lvl_t  lvl_q[$];

   int          total = 0;
   int          bad = 0;
   int unsigned cyc = 0;

   // Reference model: what the current miss has gathered so far.
   int              m_mode = M_IDLE;
   int              m_words = 0;
   int              m_off = 0;
   logic [OB-1:0]   m_req = '0;
   logic [WB-1:0]   m_vic = '0;
   logic [AW-1:0]   m_line = '0;

   task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   // Expected behaviour for the inputs applied in the current cycle.
   task automatic model_cycle();
      lvl_t  l;
      fill_t f;
      ev_t   e;
      l.cyc   = cyc;
      l.stall = (m_mode != M_IDLE) || (PrRd && !Hit);
      l.req   = (m_mode == M_REQ) || (m_mode == M_FETCH);
      lvl_q.push_back(l);
      case (m_mode)
         M_IDLE: begin
            if (PrRd && Hit) begin
               e.cyc = cyc + 1;
               e.val = AW'(Hit_way);
               blk_q.push_back(e);
            end else if (PrRd) begin
               m_line = {Address[AW-1:4], 4'b0000};
               m_req  = Address[3:2];
               m_vic  = LRU_replacement_proc;
               m_mode = M_REQ;
            end
         end
         M_REQ: begin
            if (Com_Bus_Gnt) begin
               m_mode  = M_FETCH;
               m_words = 0;
`ifdef ICACHE_CWF_EN
               m_off = int'(m_req);
`else
               m_off = 0;
`endif
            end
         end
         M_FETCH: begin
            if (!Com_Bus_Gnt) begin
               m_mode = M_REQ;
            end else if (Mem_Rdy) begin
               f.cyc  = cyc;
               f.way  = m_vic;
               f.off  = OB'(m_off);
               f.data = Data_Bus_Com;
               f.addr = m_line + AW'(m_off * 4);
               fill_q.push_back(f);
               if (m_off == int'(m_req)) begin
                  e.cyc = cyc + 1;
                  e.val = Data_Bus_Com;
                  db_q.push_back(e);
               end
               m_off = (m_off + 1) % BW;
               m_words++;
               if (m_words == BW) begin
                  e.cyc = cyc + 1;
                  e.val = AW'(m_vic);
                  blk_q.push_back(e);
                  m_mode = M_UPD;
               end
            end
         end
         default: m_mode = M_IDLE;
      endcase
   endtask

   task automatic drive_cycle(input int pr_pct, input int gnt_pct, input int rdy_pct);
      @(negedge clk);
      cyc++;
      rst_n                = 1'b1;
      PrRd                 = ($urandom_range(99) < pr_pct);
      Hit                  = ($urandom_range(99) < 50);
      Hit_way              = WB'($urandom);
      LRU_replacement_proc = WB'($urandom);
      Address              = $urandom;
      Com_Bus_Gnt          = ($urandom_range(99) < gnt_pct);
      Mem_Rdy              = ($urandom_range(99) < rdy_pct);
      Data_Bus_Com         = $urandom;
      model_cycle();
   endtask

   // Reset with bus inputs active, which must be ignored; outputs checked at once.
   task automatic do_reset();
      @(negedge clk);
      cyc++;
      rst_n        = 1'b0;
      PrRd         = 1'b0;
      Hit          = 1'b0;
      Com_Bus_Gnt  = 1'b1;
      Mem_Rdy      = 1'b1;
      Data_Bus_Com = $urandom;
      blk_q.delete();
      db_q.delete();
      fill_q.delete();
      lvl_q.delete();
      m_mode = M_IDLE;
      #1;
      check("rst_blk_valid", AW'(Blk_access_valid), '0);
      check("rst_blk_acc",   AW'(Blk_accessed), '0);
      check("rst_db_valid",  AW'(Data_Bus_valid), '0);
      check("rst_data_bus",  Data_Bus, '0);
      check("rst_bus_req",   AW'(Com_Bus_Req), '0);
      check("rst_fill_we",   AW'(Fill_we), '0);
      check("rst_fill_data", Fill_data, '0);
      check("rst_stall",     AW'(CPU_stall), '0);
      repeat (2) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   // Monitor: compares DUT outputs against the queued expectations every cycle.
   initial begin
      lvl_t  l;
      fill_t f;
      ev_t   e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            if (lvl_q.size() == 0) begin
               check("lvl_queue_empty", 32'd1, 32'd0);
            end else begin
               l = lvl_q.pop_front();
               check("cpu_stall", AW'(CPU_stall), AW'(l.stall));
               check("com_bus_req", AW'(Com_Bus_Req), AW'(l.req));
            end

            if (Fill_we) begin
               if (fill_q.size() == 0) begin
                  check("unexpected_fill", AW'(Fill_offset), '1);
               end else begin
                  f = fill_q.pop_front();
                  check("fill_cycle",  AW'(cyc), AW'(f.cyc));
                  check("fill_way",    AW'(Fill_way), AW'(f.way));
                  check("fill_offset", AW'(Fill_offset), AW'(f.off));
                  check("fill_data",   Fill_data, f.data);
                  check("address_com", Address_Com, f.addr);
               end
            end else if (fill_q.size() != 0 && fill_q[0].cyc <= cyc) begin
               f = fill_q.pop_front();
               check("missing_fill", AW'(Fill_we), 32'd1);
            end

            if (Blk_access_valid) begin
               if (blk_q.size() == 0) begin
                  check("unexpected_blk_access", AW'(Blk_accessed), '1);
               end else begin
                  e = blk_q.pop_front();
                  check("blk_cycle", AW'(cyc), AW'(e.cyc));
                  check("blk_accessed", AW'(Blk_accessed), e.val);
               end
            end else if (blk_q.size() != 0 && blk_q[0].cyc <= cyc) begin
               e = blk_q.pop_front();
               check("missing_blk_access", AW'(Blk_access_valid), 32'd1);
            end

            if (Data_Bus_valid) begin
               if (db_q.size() == 0) begin
                  check("unexpected_data_valid", Data_Bus, '1);
               end else begin
                  e = db_q.pop_front();
                  check("data_cycle", AW'(cyc), AW'(e.cyc));
                  check("data_bus", Data_Bus, e.val);
               end
            end else if (db_q.size() != 0 && db_q[0].cyc <= cyc) begin
               e = db_q.pop_front();
               check("missing_data_valid", AW'(Data_Bus_valid), 32'd1);
            end
         end
      end
   end

   initial begin
      do_reset();
      // Bus always ready: minimum-latency misses and plain hits.
      repeat (200) drive_cycle(50, 100, 100);
      // Grant drops and memory gaps.
      repeat (800) drive_cycle(50, 85, 65);
      // Resets landing at random points, often mid-fill.
      for (int i = 0; i < 6; i++) begin
         repeat (20 + $urandom_range(40)) drive_cycle(60, 90, 70);
         do_reset();
      end
      repeat (800) drive_cycle(40, 75, 50);
      // Drain any miss in flight.
      repeat (20) drive_cycle(0, 100, 100);
      #5;
      check("leftover_fill", AW'(fill_q.size()), '0);
      check("leftover_blk",  AW'(blk_q.size()), '0);
      check("leftover_data", AW'(db_q.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
